// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the byte-stream instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam int WORD_BITS = 32;
  localparam int BYTE_BITS = 8;
  localparam int LEN_BYTES = 4;
  localparam int N_BYTES   = WORD_BITS / BYTE_BITS;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bundle: byte stream in, memory word-write port and status out.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LAU        = 8
);

  logic                  start_i;
  logic [LAU-1:0]        rx_data_i;
  logic                  rx_valid_i;
  logic                  rx_ready_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [DATA_WIDTH-1:0] wdata_o;
  logic [N_BYTES-1:0]    wstrb_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  err_o;

  modport slave (
    input  start_i, rx_data_i, rx_valid_i,
    output rx_ready_o, we_o, waddr_o, wdata_o, wstrb_o, busy_o, done_o, err_o
  );

  modport master (
    output start_i, rx_data_i, rx_valid_i,
    input  rx_ready_o, we_o, waddr_o, wdata_o, wstrb_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: drops each byte into the next lane and
// accumulates the matching strobe bit until cleared.
module byte_packer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int LAU        = 8,
  localparam int LANES      = DATA_WIDTH / LAU,
  localparam int LANE_W     = $clog2(LANES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr,
  input  logic                  push,
  input  logic [LAU-1:0]        din,
  output logic [DATA_WIDTH-1:0] word,
  output logic [LANES-1:0]      strb,
  output logic                  last_lane
);

  logic [LANE_W-1:0] lane;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word <= '0;
      strb <= '0;
      lane <= '0;
    end else if (clr) begin
      word <= '0;
      strb <= '0;
      lane <= '0;
    end else if (push) begin
      word[lane*LAU +: LAU] <= din;
      strb[lane]            <= 1'b1;
      lane                  <= lane + 1'b1;
    end
  end

  // High while the next pushed byte completes the word.
  assign last_lane = (lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that packs payload bytes into
// little-endian words and writes them to instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LAU        = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           MAX_BYTES  = 2**20
) (
  input logic          clk_i,
  input logic          rst_ni,
  imem_loader_if.slave bus
);

  state_t                state_q, state_d;
  logic [31:0]           len_q, cnt_q, len_full, cnt_inc;
  logic [1:0]            len_idx_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  ready_q, we_q, busy_q, done_q, err_q;
  logic                  ready_d, we_d, busy_d, done_d, err_d;
  logic                  accept, launch, last_lane;
  logic [DATA_WIDTH-1:0] pk_word;
  logic [N_BYTES-1:0]    pk_strb;

  assign accept   = bus.rx_valid_i & ready_q;
  assign launch   = (state_d == LEN) && (state_q != LEN);
  assign len_full = {bus.rx_data_i, len_q[23:0]};
  assign cnt_inc  = cnt_q + 32'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (bus.start_i) state_d = LEN;
      LEN: begin
        if (accept && len_idx_q == 2'(LEN_BYTES - 1)) begin
          if (len_full == 32'd0)          state_d = DONE;
          else if (len_full > MAX_BYTES)  state_d = ERR;
          else                            state_d = DATA;
        end
      end
      DATA:    if (accept && (last_lane || cnt_inc == len_q)) state_d = WRITE;
      WRITE:   state_d = (cnt_q == len_q) ? DONE : DATA;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so every port comes straight from a flop.
  always_comb begin
    ready_d = (state_d == LEN) || (state_d == DATA);
    busy_d  = (state_d == LEN) || (state_d == DATA) || (state_d == WRITE);
    we_d    = (state_d == WRITE);
    done_d  = (state_d == DONE);
    err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q     <= '0;
      cnt_q     <= '0;
      len_idx_q <= '0;
      waddr_q   <= '0;
    end else begin
      if (launch) begin
        cnt_q     <= '0;
        len_idx_q <= '0;
      end
      if (accept && state_q == LEN) begin
        len_q[len_idx_q*LAU +: LAU] <= bus.rx_data_i;
        len_idx_q                   <= len_idx_q + 2'd1;
      end
      if (accept && state_q == DATA) cnt_q <= cnt_inc;
      // cnt_q still holds the index of the completing byte here.
      if (state_q == DATA && state_d == WRITE)
        waddr_q <= BASE_ADDR + ADDR_WIDTH'({cnt_q[31:2], 2'b00});
    end
  end

  byte_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .LAU       (LAU)
  ) u_packer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr      (launch || (state_q == WRITE)),
    .push     (accept && (state_q == DATA)),
    .din      (bus.rx_data_i),
    .word     (pk_word),
    .strb     (pk_strb),
    .last_lane(last_lane)
  );

  assign bus.rx_ready_o = ready_q;
  assign bus.we_o       = we_q;
  assign bus.waddr_o    = waddr_q;
  assign bus.wdata_o    = pk_word;
  assign bus.wstrb_o    = pk_strb;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-list and
// byte-memory model derived from the stream format.
module tb_imem_loader;

  localparam int          MAXB = 1024;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LAU(8)) ifc ();

  imem_loader #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .LAU       (8),
    .BASE_ADDR (BASE),
    .MAX_BYTES (MAXB)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (ifc)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  pay[$];
  logic [7:0]  mem [int unsigned];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_writes = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
  endtask

  task automatic check_reset_outputs();
    check("rst_rx_ready", ifc.rx_ready_o, 0);
    check("rst_we",       ifc.we_o,       0);
    check("rst_waddr",    ifc.waddr_o,    0);
    check("rst_wdata",    ifc.wdata_o,    0);
    check("rst_wstrb",    ifc.wstrb_o,    0);
    check("rst_busy",     ifc.busy_o,     0);
    check("rst_done",     ifc.done_o,     0);
    check("rst_err",      ifc.err_o,      0);
  endtask

  // Expected word writes: payload byte k lands in lane k%4 of word k/4.
  task automatic build_expected(input int n);
    wr_t w;
    exp_q.delete();
    if (n == 0 || n > MAXB) return;
    for (int wi = 0; wi < (n + 3) / 4; wi++) begin
      w.addr = BASE + 32'(4 * wi);
      w.data = '0;
      w.strb = '0;
      for (int j = 0; j < 4; j++) begin
        if (4 * wi + j < n) begin
          w.data[8*j +: 8] = pay[4*wi + j];
          w.strb[j]        = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  // Every write cycle is compared against the model and mirrored into mem.
  initial begin
    logic pw;
    wr_t  e;
    pw = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pw = 1'b0;
      end else begin
        if (ifc.we_o) begin
          check("we_single_cycle", pw, 0);
          check("rdy_during_write", ifc.rx_ready_o, 0);
          n_writes++;
          for (int j = 0; j < 4; j++)
            if (ifc.wstrb_o[j]) mem[ifc.waddr_o + 32'(j)] = ifc.wdata_o[8*j +: 8];
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("waddr", ifc.waddr_o, e.addr);
            check("wdata", ifc.wdata_o, e.data);
            check("wstrb", ifc.wstrb_o, e.strb);
          end
        end
        pw = ifc.we_o;
      end
    end
  end

  task automatic do_start();
    ifc.start_i = 1'b1;
    @(posedge clk); #1;
    ifc.start_i = 1'b0;
    check("start_rdy",      ifc.rx_ready_o, 1);
    check("start_busy",     ifc.busy_o,     1);
    check("start_clr_done", ifc.done_o,     0);
    check("start_clr_err",  ifc.err_o,      0);
  endtask

  task automatic run_load(input int n, input int abort_at, input bit gaps);
    logic [7:0]  st[$];
    logic [31:0] nn;
    int          waits, errs, w0, words;
    bit          rdy;
    nn    = 32'(n);
    w0    = n_writes;
    words = (n == 0 || n > MAXB) ? 0 : (n + 3) / 4;
    mem.delete();
    st.push_back(nn[7:0]);
    st.push_back(nn[15:8]);
    st.push_back(nn[23:16]);
    st.push_back(nn[31:24]);
    if (n <= MAXB) foreach (pay[k]) st.push_back(pay[k]);
    do_start();
    for (int i = 0; i < st.size(); i++) begin
      if (abort_at >= 0 && i == 4 + abort_at) begin
        ifc.rx_valid_i = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        ifc.rx_valid_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      ifc.rx_valid_i = 1'b1;
      ifc.rx_data_i  = st[i];
      waits = 0;
      forever begin
        rdy         = ifc.rx_ready_o;
        ifc.start_i = ($urandom_range(0, 7) == 0);
        @(posedge clk); #1;
        if (rdy) break;
        waits++;
        if (waits > 20) begin
          check("accept_timeout", waits, 0);
          ifc.rx_valid_i = 1'b0;
          ifc.start_i    = 1'b0;
          return;
        end
      end
      ifc.start_i = 1'b0;
      if (i == 3) begin
        if (n == 0) begin
          check("n0_done", ifc.done_o, 1);
        end else if (n > MAXB) begin
          check("err_flag", ifc.err_o, 1);
          check("err_rdy",  ifc.rx_ready_o, 0);
        end
      end else if (i >= 4) begin
        if ((i - 4) % 4 == 3 || i - 4 == n - 1) check("we_timing", ifc.we_o, 1);
        else                                    check("we_idle",   ifc.we_o, 0);
      end
    end
    ifc.rx_valid_i = 1'b0;
    if (n > 0 && n <= MAXB) begin
      @(posedge clk); #1;
      check("done_timing", ifc.done_o, 1);
      check("busy_end",    ifc.busy_o, 0);
      errs = 0;
      for (int k = 0; k < n; k++)
        if (!mem.exists(BASE + 32'(k)) || mem[BASE + 32'(k)] !== pay[k]) errs++;
      check("mem_image", errs, 0);
    end
    check("writes_left", exp_q.size(), 0);
    check("write_count", n_writes - w0, words);
  endtask

  task automatic random_payload(input int n);
    pay.delete();
    for (int k = 0; k < n; k++) pay.push_back(8'($urandom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int errs;
    ifc.start_i    = 1'b0;
    ifc.rx_valid_i = 1'b0;
    ifc.rx_data_i  = 8'h00;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();

    pay = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    build_expected(8);
    check("model_w0_addr", exp_q[0].addr, 32'h0000_0100);
    check("model_w0_data", exp_q[0].data, 32'h0000_0013);
    check("model_w1_data", exp_q[1].data, 32'h0010_0093);
    check("model_w1_strb", exp_q[1].strb, 4'b1111);
    run_load(8, -1, 1'b0);

    pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_expected(6);
    check("model_p0_data", exp_q[0].data, 32'h0403_0201);
    check("model_p1_addr", exp_q[1].addr, 32'h0000_0104);
    check("model_p1_data", exp_q[1].data, 32'h0000_0605);
    check("model_p1_strb", exp_q[1].strb, 4'b0011);
    run_load(6, -1, 1'b0);

    pay.delete();
    build_expected(0);
    check("model_n0_empty", exp_q.size(), 0);
    run_load(0, -1, 1'b0);

    build_expected(32'h401);
    run_load(32'h401, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 40);
      random_payload(n);
      build_expected(n);
      run_load(n, -1, 1'b1);
    end

    random_payload(MAXB);
    build_expected(MAXB);
    run_load(MAXB, -1, 1'b0);

    random_payload(12);
    build_expected(12);
    run_load(12, 5, 1'b0);
    errs = 0;
    for (int k = 0; k < 4; k++)
      if (!mem.exists(BASE + 32'(k)) || mem[BASE + 32'(k)] !== pay[k]) errs++;
    check("abort_word_kept", errs, 0);
    check("abort_no_word1", mem.exists(BASE + 32'd4), 0);
    build_expected(12);
    run_load(12, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
